// File: rtl/common_pkg.sv
// Shared types and constants for the iterative divider: operation codes,
// controller states and the fixed issue-to-done latency.
package common_pkg;

    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIV_U = 2'b01,
        REM_S = 2'b10,
        REM_U = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

    localparam int DIV_LATENCY = 35;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring iteration: shift {rem,quot} left and trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0] rem_sh_s;
    logic [WIDTH:0] diff_s;

    // rem < divisor is invariant, so the top bit of the WIDTH+1 difference is its sign
    assign rem_sh_s = {rem_i, quot_i[WIDTH-1]};
    assign diff_s   = rem_sh_s - {1'b0, divisor_i};
    assign rem_o    = diff_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
    assign quot_o   = {quot_i[WIDTH-2:0], ~diff_s[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU iterative restoring divider with start/busy/done handshake.
// Optional build macro: DIV_FAST_SPECIAL_EN (divide-by-zero and overflow finish from PREP).
module div_unit
    import common_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  div_op_t          div_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             insert_bubble
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    div_op_t          op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] rem_step_s, quot_step_s;
    logic             signed_s, is_div_s, a_neg_s, b_neg_s, prep_dz_s, prep_ovf_s;

    // Result for divide-by-zero / overflow; a_q always holds the original dividend
    function automatic logic [WIDTH-1:0] special_result(input logic is_div,
                                                        input logic dz,
                                                        input logic [WIDTH-1:0] a);
        if (dz) begin
            return is_div ? {WIDTH{1'b1}} : a;
        end else begin
            return is_div ? MIN_NEG : {WIDTH{1'b0}};
        end
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (b_q),
        .rem_o     (rem_step_s),
        .quot_o    (quot_step_s)
    );

    assign signed_s   = ~op_q[0];
    assign is_div_s   = ~op_q[1];
    assign a_neg_s    = signed_s & a_q[WIDTH-1];
    assign b_neg_s    = signed_s & b_q[WIDTH-1];
    assign prep_dz_s  = (b_q == {WIDTH{1'b0}});
    assign prep_ovf_s = signed_s && (a_q == MIN_NEG) && (b_q == {WIDTH{1'b1}});

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = div_op;
                    a_d     = dividend;
                    b_d     = divisor;
                    state_d = PREP;
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
                qneg_d = a_neg_s ^ b_neg_s;
                rneg_d = a_neg_s;
                b_d    = b_neg_s ? -b_q : b_q;
                quot_d = a_neg_s ? -a_q : a_q;
                rem_d  = {WIDTH{1'b0}};
                cnt_d  = {CNT_W{1'b0}};
                dz_d   = prep_dz_s;
                ovf_d  = prep_ovf_s;
`ifdef DIV_FAST_SPECIAL_EN
                if (prep_dz_s || prep_ovf_s) begin
                    result_d = special_result(is_div_s, prep_dz_s, a_q);
                    state_d  = DONE;
                end else begin
                    state_d = CALC;
                end
`else
                state_d = CALC;
`endif
            end
            CALC: begin
                rem_d  = rem_step_s;
                quot_d = quot_step_s;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                if (dz_q || ovf_q) begin
                    result_d = special_result(is_div_s, dz_q, a_q);
                end else if (is_div_s) begin
                    result_d = qneg_q ? -quot_q : quot_q;
                end else begin
                    result_d = rneg_q ? -rem_q : rem_q;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= DIV_S;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            rem_q    <= {WIDTH{1'b0}};
            quot_q   <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result        = result_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign insert_bubble = ((state_q == IDLE) && start) || (state_q == PREP) ||
                           (state_q == CALC) || (state_q == FIX);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases, mid-flight
// start/reset behaviour and randomized operands against an arithmetic reference.
module tb_div_unit;
    import common_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    div_op_t     div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        insert_bubble;

    int n_cmp = 0;
    int n_err = 0;

    div_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .div_op        (div_op),
        .dividend      (dividend),
        .divisor       (divisor),
        .result        (result),
        .busy          (busy),
        .done          (done),
        .insert_bubble (insert_bubble)
    );

    always #5 clk = ~clk;

    // RISC-V M semantics from plain 64-bit arithmetic (truncating division)
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        logic [63:0] qv, rv;
        bit is_div;
        bit is_sgn;
        is_div = (op == 2'b00) || (op == 2'b01);
        is_sgn = (op == 2'b00) || (op == 2'b10);
        if (b == 32'd0) return is_div ? 32'hFFFF_FFFF : a;
        if (is_sgn) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        qv = q;
        rv = r;
        return is_div ? qv[31:0] : rv[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation in the current cycle and check every cycle up to the return to IDLE
    task automatic do_op(input div_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input int poke_cyc, input bit poke_done, input string tag);
        logic [31:0] exp;
        logic [1:0]  o;
        int          lat;
        o   = op;
        exp = ref_model(o, a, b);
        lat = DIV_LATENCY;
`ifdef DIV_FAST_SPECIAL_EN
        if ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) lat = 2;
`endif
        div_op   = op;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        #1;
        chk($sformatf("%s bubble@0", tag), {31'd0, insert_bubble}, 32'd1);
        chk($sformatf("%s busy@0", tag), {31'd0, busy}, 32'd0);
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        div_op   = div_op_t'($urandom_range(0, 3));
        for (int c = 1; c <= lat; c++) begin
            start = 1'b0;
            if ((c == poke_cyc) || (poke_done && c == lat)) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom_range(1, 9);
                div_op   = div_op_t'($urandom_range(0, 3));
            end
            #1;
            if (c < lat) begin
                chk($sformatf("%s bubble@%0d", tag, c), {31'd0, insert_bubble}, 32'd1);
                chk($sformatf("%s done@%0d", tag, c), {31'd0, done}, 32'd0);
            end else begin
                chk($sformatf("%s done@%0d", tag, c), {31'd0, done}, 32'd1);
                chk($sformatf("%s bubble@%0d", tag, c), {31'd0, insert_bubble}, 32'd0);
                chk($sformatf("%s result", tag), result, exp);
            end
            chk($sformatf("%s busy@%0d", tag, c), {31'd0, busy}, 32'd1);
            tick();
        end
        start = 1'b0;
        #1;
        chk($sformatf("%s idle busy", tag), {31'd0, busy}, 32'd0);
        chk($sformatf("%s idle done", tag), {31'd0, done}, 32'd0);
        chk($sformatf("%s held result", tag), result, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          sel;
        rst_n    = 1'b0;
        start    = 1'b0;
        div_op   = DIV_S;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset bubble", {31'd0, insert_bubble}, 32'd0);
        chk("reset result", result, 32'd0);
        rst_n = 1'b1;
        tick();

        do_op(DIV_U, 32'd100, 32'd7, 0, 1'b0, "divu_100_7");
        do_op(REM_U, 32'd100, 32'd7, 0, 1'b0, "remu_100_7");
        do_op(DIV_S, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "divs_m7_2");
        do_op(REM_S, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, "rems_m7_2");
        do_op(DIV_S, 32'd7, 32'hFFFF_FFFE, 0, 1'b0, "divs_7_m2");
        do_op(DIV_U, 32'd5, 32'd0, 0, 1'b0, "divu_by0");
        do_op(REM_U, 32'd5, 32'd0, 0, 1'b0, "remu_by0");
        do_op(DIV_S, 32'hFFFF_FFFB, 32'd0, 0, 1'b0, "divs_by0");
        do_op(REM_S, 32'hFFFF_FFFB, 32'd0, 0, 1'b0, "rems_by0");
        do_op(DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "divs_ovf");
        do_op(REM_S, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, "rems_ovf");
        do_op(DIV_U, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, "divu_max_1");

        // start pulsed mid-flight and in DONE are ignored; back-to-back issue follows directly
        do_op(DIV_U, 32'd1000, 32'd9, 10, 1'b1, "ignore_start");
        do_op(REM_S, 32'h8765_4321, 32'd1234, 0, 1'b0, "back_to_back");

        // synchronous reset in cycle 20 aborts the operation
        div_op   = DIV_U;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        tick();
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort bubble", {31'd0, insert_bubble}, 32'd0);
        rst_n = 1'b1;
        tick();
        do_op(DIV_S, 32'hFFFF_FC18, 32'd7, 0, 1'b0, "after_abort");

        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 7);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) rb = $urandom_range(1, 15);
            else if (sel == 2) begin
                rb = 32'hFFFF_FFFF;
                if (ra[0]) ra = 32'h8000_0000;
            end else if (sel == 3) rb = rb >> $urandom_range(0, 31);
            do_op(div_op_t'($urandom_range(0, 3)), ra, rb, 0, 1'b0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider that implements RV32M DIV, DIVU, REM and REMU.
- It is the inverse of the ALU's pipelined multiplier and fills the ALU_DIV slot.
- It sits beside the ALU in the execute stage.
- It uses a start/busy/done handshake and raises insert_bubble to stall the pipeline until the result is valid, the same contract the multiplier uses.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a division; sampled only in IDLE.
- div_op  in  div_op_t (2)  DIV_S, DIV_U, REM_S, REM_U.
- dividend  in  WIDTH  left operand.
- divisor  in  WIDTH  right operand.
- result  out  WIDTH  quotient or remainder; held until the next accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the DONE state; result is valid in that cycle.
- insert_bubble  out  1  pipeline stall request.

Behaviour:
- Reset (rst_n=0 at a clock edge): state goes to IDLE; result=0, busy=0, done=0, insert_bubble=0; counter and datapath registers cleared. This applies mid-operation too; the operation in flight is aborted silently.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE: on start=1, latch div_op, dividend and divisor, then go to PREP. Without start, stay in IDLE.
- PREP:
  - Record the quotient sign as sign(dividend) ^ sign(divisor), signed ops only.
  - Record the remainder sign as sign(dividend).
  - Replace the operands with their absolute values for signed ops.
  - Flag div_zero = (divisor==0).
  - Flag ovf = signed op && dividend==0x80000000 && divisor==0xFFFFFFFF.
  - Load rem_acc=0, quot=|dividend|, cnt=0.
- CALC, one bit per cycle, WIDTH cycles:
  - Shift {rem_acc,quot} left by 1.
  - Trial-subtract the divisor from rem_acc, using WIDTH+1-bit arithmetic.
  - If the difference is non-negative, keep it and set the quot LSB to 1; otherwise restore.
  - cnt increments each cycle; leave CALC when cnt==WIDTH-1.
- FIX, in priority order:
  1. div_zero: quotient = all ones for both signed and unsigned; remainder = original dividend.
  2. ovf: quotient = 0x80000000; remainder = 0.
  3. Otherwise: negate the quotient if its sign is negative; negate the remainder if the dividend was negative (signed ops).
  - result register <= quotient for DIV_*, remainder for REM_*.
- DONE: done=1 for exactly one cycle; busy=1; unconditional return to IDLE.
- Latency: start sampled in cycle 0 gives PREP in cycle 1, CALC in cycles 2..33, FIX in cycle 34, and DONE (done=1) in cycle 35.
- insert_bubble is combinational:
  - High when (state==IDLE && start).
  - High when the state is PREP, CALC or FIX.
  - Low in DONE and in IDLE without start.
  - The stalled instruction therefore consumes result in cycle 35.
- start while busy: ignored; no queueing, latched operands unchanged.
- start asserted in the same cycle as DONE: ignored. start in the following IDLE cycle is accepted, so back-to-back issue is allowed.
- Operand inputs need only be valid in the cycle start is sampled.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- When defined:
  - PREP branches directly to DONE when div_zero or ovf is set, writing the FIX-rule result in that transition.
  - done occurs in cycle 2, and insert_bubble drops accordingly.
  - Normal operands keep the 35-cycle latency.
- When undefined: every operation takes 35 cycles, and special-case values are produced in FIX.
- Results are identical either way.

Decomposition:
- common_pkg gets:
  - the div_op_t enum (DIV_S=2'b00, DIV_U=2'b01, REM_S=2'b10, REM_U=2'b11);
  - the div_state_t enum (IDLE, PREP, CALC, FIX, DONE);
  - the constant DIV_LATENCY=35.
- One natural sub-module: div_step, a combinational single-iteration shift/trial-subtract cell. All control and sign handling stay in div_unit.

Test Plan:
- DIV_U 100/7, start in cycle 0 -> insert_bubble high in cycles 0..34, done high only in cycle 35, result=14. REM_U 100%7 -> result=2.
- DIV_S 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM_S -7 % 2 -> 0xFFFFFFFF (-1). DIV_S 7 / -2 -> 0xFFFFFFFD.
- Divide by zero:
  - DIV_U 5/0 -> 0xFFFFFFFF; REM_U 5/0 -> 5.
  - DIV_S -5/0 -> 0xFFFFFFFF; REM_S -5/0 -> 0xFFFFFFFB.
  - With DIV_FAST_SPECIAL_EN, done arrives in cycle 2.
- Overflow: DIV_S 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM_S -> 0.
- Second start pulsed in cycle 10 with different operands -> ignored; first result unchanged in cycle 35. A new start in cycle 36 -> done in cycle 71.
- rst_n=0 in cycle 20 -> cycle 21 shows busy=0, done=0, result=0, insert_bubble=0. A fresh start then completes with correct timing.
